cc_output_serializer: RTL and testbench

- Sits between cache controller stage 4 and the network interface (NI).
- Buffers the three outgoing coherence message classes (request, response, forwarded request) in independent FIFOs.
- Splits two-destination request/response messages into back-to-back unicast beats, because the NI port is unicast-only.
- Raises per-class almost-full back-pressure so the cache controller pipeline stalls before stage 3 issues.

---
 rtl/cc_output_serializer_pkg.sv | 56 +++++
 rtl/cc_out_fifo.sv | 70 +++++++
 rtl/cc_output_serializer.sv | 167 ++++++++++++++++
 tb/tb_cc_output_serializer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_output_serializer_pkg.sv
// Shared coherence/network types and the queued-entry layout used by the output serializer.
package cc_output_serializer_pkg;

  localparam int unsigned TILE_COUNT  = 16;
  localparam int unsigned TILE_ADDR_W = $clog2(TILE_COUNT);
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned MSG_TYPE_W  = 4;
  localparam int unsigned MSG_W       = MSG_TYPE_W + ADDR_W + TILE_ADDR_W;

  typedef logic [TILE_ADDR_W-1:0] tile_address_t;

  // Index into a two-entry destination list
  localparam logic CC_ID = 1'b1;
  localparam logic DC_ID = 1'b0;

  typedef struct packed {
    logic [MSG_TYPE_W-1:0] packet_type;
    logic [ADDR_W-1:0]     address;
    tile_address_t         requestor;
  } coherence_request_message_t;

  typedef struct packed {
    logic [MSG_TYPE_W-1:0] packet_type;
    logic [ADDR_W-1:0]     address;
    tile_address_t         source;
  } coherence_response_message_t;

  typedef struct packed {
    logic [MSG_TYPE_W-1:0] packet_type;
    logic [ADDR_W-1:0]     address;
    tile_address_t         requestor;
  } coherence_forwarded_message_t;

  // Queued request/response entry
  typedef struct packed {
    logic [MSG_W-1:0]    payload;
    logic                has_data;
    tile_address_t [1:0] destinations;
    logic [1:0]          destinations_valid;
  } cc_out_entry_t;

  // Queued forwarded-request entry (always single destination)
  typedef struct packed {
    logic [MSG_W-1:0] payload;
    tile_address_t    destination;
  } cc_out_fwd_entry_t;

  localparam int unsigned ENTRY_W     = $bits(cc_out_entry_t);
  localparam int unsigned FWD_ENTRY_W = $bits(cc_out_fwd_entry_t);

  typedef enum logic {
    SEND_FIRST  = 1'b0,
    SEND_SECOND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/cc_out_fifo.sv
// Generic synchronous FIFO with a registered almost-full flag and overflow strobe.
module cc_out_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_c,
  output logic             o_empty_c,
  output logic             o_overflow_c,
  output logic             o_almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_almost_full;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty_c     = (r_count == '0);
  assign w_full        = (r_count == CNT_W'(DEPTH));
  assign w_pop_ok      = i_pop && !o_empty_c;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign w_push_ok     = i_push && (!w_full || w_pop_ok);
  assign o_overflow_c  = i_push && !w_push_ok;
  assign o_head_c      = r_mem[r_rd_ptr];
  assign o_almost_full = r_almost_full;

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy and almost-full flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count       <= w_count_nxt;
      r_almost_full <= (w_count_nxt >= CNT_W'(AF_LEVEL));
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/cc_output_serializer.sv
// Buffers request/response/forwarded coherence messages and emits unicast beats to the NI.
module cc_output_serializer
  import cc_output_serializer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned ALMOST_FULL_SLACK = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cc4_request_valid,
  input  coherence_request_message_t   cc4_request,
  input  logic                         cc4_request_has_data,
  input  tile_address_t [1:0]          cc4_request_destinations,
  input  logic [1:0]                   cc4_request_destinations_valid,
  input  logic                         cc4_response_valid,
  input  coherence_response_message_t  cc4_response,
  input  logic                         cc4_response_has_data,
  input  tile_address_t [1:0]          cc4_response_destinations,
  input  logic [1:0]                   cc4_response_destinations_valid,
  input  logic                         cc4_forwarded_request_valid,
  input  coherence_forwarded_message_t cc4_forwarded_request,
  input  tile_address_t                cc4_forwarded_request_destination,
  input  logic                         ni_request_network_available,
  input  logic                         ni_response_network_available,
  input  logic                         ni_forwarded_request_network_available,
  output logic                         cco_request_valid,
  output coherence_request_message_t   cco_request,
  output logic                         cco_request_has_data,
  output tile_address_t                cco_request_destination,
  output logic                         cco_response_valid,
  output coherence_response_message_t  cco_response,
  output logic                         cco_response_has_data,
  output tile_address_t                cco_response_destination,
  output logic                         cco_forwarded_request_valid,
  output coherence_forwarded_message_t cco_forwarded_request,
  output tile_address_t                cco_forwarded_request_destination,
  output logic                         cco_request_almost_full,
  output logic                         cco_response_almost_full,
  output logic                         cco_forwarded_almost_full,
  output logic                         cco_overflow_error
);

  localparam int unsigned AF_LEVEL = FIFO_DEPTH - ALMOST_FULL_SLACK;

  cc_out_entry_t     w_req_in, w_req_head, w_rsp_in, w_rsp_head;
  cc_out_fwd_entry_t w_fwd_in, w_fwd_head;
  logic w_req_push, w_req_pop, w_req_empty, w_req_ovf, w_req_xfer;
  logic w_rsp_push, w_rsp_pop, w_rsp_empty, w_rsp_ovf, w_rsp_xfer;
  logic w_fwd_pop, w_fwd_empty, w_fwd_ovf;
  ser_state_t r_req_state, w_req_state_nxt;
  ser_state_t r_rsp_state, w_rsp_state_nxt;
  logic r_overflow;

  assign w_req_in.payload            = cc4_request;
  assign w_req_in.has_data           = cc4_request_has_data;
  assign w_req_in.destinations       = cc4_request_destinations;
  assign w_req_in.destinations_valid = cc4_request_destinations_valid;
  assign w_rsp_in.payload            = cc4_response;
  assign w_rsp_in.has_data           = cc4_response_has_data;
  assign w_rsp_in.destinations       = cc4_response_destinations;
  assign w_rsp_in.destinations_valid = cc4_response_destinations_valid;
  assign w_fwd_in.payload            = cc4_forwarded_request;
  assign w_fwd_in.destination        = cc4_forwarded_request_destination;

  // Messages with no valid destination are silently discarded
  assign w_req_push = cc4_request_valid  && (cc4_request_destinations_valid  != 2'b00);
  assign w_rsp_push = cc4_response_valid && (cc4_response_destinations_valid != 2'b00);

  cc_out_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH), .AF_LEVEL(AF_LEVEL)) u_req_fifo (
    .clk(clk), .reset(reset), .i_push(w_req_push), .i_data(w_req_in), .i_pop(w_req_pop),
    .o_head_c(w_req_head), .o_empty_c(w_req_empty), .o_overflow_c(w_req_ovf),
    .o_almost_full(cco_request_almost_full)
  );

  cc_out_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH), .AF_LEVEL(AF_LEVEL)) u_rsp_fifo (
    .clk(clk), .reset(reset), .i_push(w_rsp_push), .i_data(w_rsp_in), .i_pop(w_rsp_pop),
    .o_head_c(w_rsp_head), .o_empty_c(w_rsp_empty), .o_overflow_c(w_rsp_ovf),
    .o_almost_full(cco_response_almost_full)
  );

  cc_out_fifo #(.WIDTH(FWD_ENTRY_W), .DEPTH(FIFO_DEPTH), .AF_LEVEL(AF_LEVEL)) u_fwd_fifo (
    .clk(clk), .reset(reset), .i_push(cc4_forwarded_request_valid), .i_data(w_fwd_in),
    .i_pop(w_fwd_pop), .o_head_c(w_fwd_head), .o_empty_c(w_fwd_empty),
    .o_overflow_c(w_fwd_ovf), .o_almost_full(cco_forwarded_almost_full)
  );

  assign cco_request_valid    = !w_req_empty;
  assign cco_request          = w_req_head.payload;
  assign cco_request_has_data = w_req_head.has_data;
  assign w_req_xfer           = cco_request_valid && ni_request_network_available;

  assign cco_response_valid    = !w_rsp_empty;
  assign cco_response          = w_rsp_head.payload;
  assign cco_response_has_data = w_rsp_head.has_data;
  assign w_rsp_xfer            = cco_response_valid && ni_response_network_available;

  assign cco_forwarded_request_valid       = !w_fwd_empty;
  assign cco_forwarded_request             = w_fwd_head.payload;
  assign cco_forwarded_request_destination = w_fwd_head.destination;
  assign w_fwd_pop = cco_forwarded_request_valid && ni_forwarded_request_network_available;

  // Serializer phase registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_state <= SEND_FIRST;
      r_rsp_state <= SEND_FIRST;
    end else begin
      r_req_state <= w_req_state_nxt;
      r_rsp_state <= w_rsp_state_nxt;
    end
  end

  // Request beat selection: CC destination first, DC second; pop only on the final beat
  always_comb begin
    w_req_state_nxt        = r_req_state;
    w_req_pop              = 1'b0;
    cco_request_destination = w_req_head.destinations[DC_ID];
    case (r_req_state)
      SEND_FIRST: begin
        if (w_req_head.destinations_valid[CC_ID])
          cco_request_destination = w_req_head.destinations[CC_ID];
        if (w_req_xfer) begin
          if (&w_req_head.destinations_valid) w_req_state_nxt = SEND_SECOND;
          else                                w_req_pop       = 1'b1;
        end
      end
      SEND_SECOND: begin
        if (w_req_xfer) begin
          w_req_pop       = 1'b1;
          w_req_state_nxt = SEND_FIRST;
        end
      end
    endcase
  end

  // Response beat selection, identical policy to requests
  always_comb begin
    w_rsp_state_nxt         = r_rsp_state;
    w_rsp_pop               = 1'b0;
    cco_response_destination = w_rsp_head.destinations[DC_ID];
    case (r_rsp_state)
      SEND_FIRST: begin
        if (w_rsp_head.destinations_valid[CC_ID])
          cco_response_destination = w_rsp_head.destinations[CC_ID];
        if (w_rsp_xfer) begin
          if (&w_rsp_head.destinations_valid) w_rsp_state_nxt = SEND_SECOND;
          else                                w_rsp_pop       = 1'b1;
        end
      end
      SEND_SECOND: begin
        if (w_rsp_xfer) begin
          w_rsp_pop       = 1'b1;
          w_rsp_state_nxt = SEND_FIRST;
        end
      end
    endcase
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)                                r_overflow <= 1'b0;
    else if (w_req_ovf || w_rsp_ovf || w_fwd_ovf) r_overflow <= 1'b1;
  end

  assign cco_overflow_error = r_overflow;

endmodule

// File: tb/tb_cc_output_serializer.sv
// Self-checking bench: vector table, directed multi-cycle sequences and a per-cycle scoreboard.
module tb_cc_output_serializer;
  import cc_output_serializer_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF_AT = 5;

  logic clk = 1'b0;
  logic reset;
  logic cc4_request_valid, cc4_request_has_data;
  coherence_request_message_t cc4_request;
  tile_address_t [1:0] cc4_request_destinations;
  logic [1:0] cc4_request_destinations_valid;
  logic cc4_response_valid, cc4_response_has_data;
  coherence_response_message_t cc4_response;
  tile_address_t [1:0] cc4_response_destinations;
  logic [1:0] cc4_response_destinations_valid;
  logic cc4_forwarded_request_valid;
  coherence_forwarded_message_t cc4_forwarded_request;
  tile_address_t cc4_forwarded_request_destination;
  logic ni_req, ni_rsp, ni_fwd;
  logic cco_request_valid, cco_request_has_data;
  coherence_request_message_t cco_request;
  tile_address_t cco_request_destination;
  logic cco_response_valid, cco_response_has_data;
  coherence_response_message_t cco_response;
  tile_address_t cco_response_destination;
  logic cco_forwarded_request_valid;
  coherence_forwarded_message_t cco_forwarded_request;
  tile_address_t cco_forwarded_request_destination;
  logic cco_request_almost_full, cco_response_almost_full, cco_forwarded_almost_full;
  logic cco_overflow_error;

  cc_output_serializer #(.FIFO_DEPTH(DEPTH), .ALMOST_FULL_SLACK(3)) dut (
    .clk(clk), .reset(reset),
    .cc4_request_valid(cc4_request_valid), .cc4_request(cc4_request),
    .cc4_request_has_data(cc4_request_has_data),
    .cc4_request_destinations(cc4_request_destinations),
    .cc4_request_destinations_valid(cc4_request_destinations_valid),
    .cc4_response_valid(cc4_response_valid), .cc4_response(cc4_response),
    .cc4_response_has_data(cc4_response_has_data),
    .cc4_response_destinations(cc4_response_destinations),
    .cc4_response_destinations_valid(cc4_response_destinations_valid),
    .cc4_forwarded_request_valid(cc4_forwarded_request_valid),
    .cc4_forwarded_request(cc4_forwarded_request),
    .cc4_forwarded_request_destination(cc4_forwarded_request_destination),
    .ni_request_network_available(ni_req),
    .ni_response_network_available(ni_rsp),
    .ni_forwarded_request_network_available(ni_fwd),
    .cco_request_valid(cco_request_valid), .cco_request(cco_request),
    .cco_request_has_data(cco_request_has_data), .cco_request_destination(cco_request_destination),
    .cco_response_valid(cco_response_valid), .cco_response(cco_response),
    .cco_response_has_data(cco_response_has_data), .cco_response_destination(cco_response_destination),
    .cco_forwarded_request_valid(cco_forwarded_request_valid),
    .cco_forwarded_request(cco_forwarded_request),
    .cco_forwarded_request_destination(cco_forwarded_request_destination),
    .cco_request_almost_full(cco_request_almost_full),
    .cco_response_almost_full(cco_response_almost_full),
    .cco_forwarded_almost_full(cco_forwarded_almost_full),
    .cco_overflow_error(cco_overflow_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [MSG_W-1:0] pl;
    logic             hd;
    tile_address_t    dest;
    bit               last;
  } beat_t;

  beat_t q [3][$];
  int    cnt [3];
  bit    m_ovf;

  logic             in_v [3];
  logic [1:0]       in_dv [3];
  tile_address_t    in_cc [3], in_dc [3];
  logic [MSG_W-1:0] in_pl [3];
  logic             in_hd [3];
  logic             av [3], act_v [3], act_hd [3], act_af [3];
  logic [MSG_W-1:0] act_pl [3];
  tile_address_t    act_d [3];

  // Cycle model: compare outputs against queued beats, then apply this cycle's pop and push
  always @(negedge clk) begin
    if (started) begin
      in_v[0] = cc4_request_valid;  in_dv[0] = cc4_request_destinations_valid;
      in_cc[0] = cc4_request_destinations[CC_ID]; in_dc[0] = cc4_request_destinations[DC_ID];
      in_pl[0] = cc4_request; in_hd[0] = cc4_request_has_data;
      in_v[1] = cc4_response_valid; in_dv[1] = cc4_response_destinations_valid;
      in_cc[1] = cc4_response_destinations[CC_ID]; in_dc[1] = cc4_response_destinations[DC_ID];
      in_pl[1] = cc4_response; in_hd[1] = cc4_response_has_data;
      in_v[2] = cc4_forwarded_request_valid; in_dv[2] = 2'b10;
      in_cc[2] = cc4_forwarded_request_destination; in_dc[2] = '0;
      in_pl[2] = cc4_forwarded_request; in_hd[2] = 1'b0;
      av[0] = ni_req; av[1] = ni_rsp; av[2] = ni_fwd;
      act_v[0] = cco_request_valid; act_pl[0] = cco_request;
      act_hd[0] = cco_request_has_data; act_d[0] = cco_request_destination;
      act_v[1] = cco_response_valid; act_pl[1] = cco_response;
      act_hd[1] = cco_response_has_data; act_d[1] = cco_response_destination;
      act_v[2] = cco_forwarded_request_valid; act_pl[2] = cco_forwarded_request;
      act_hd[2] = 1'b0; act_d[2] = cco_forwarded_request_destination;
      act_af[0] = cco_request_almost_full; act_af[1] = cco_response_almost_full;
      act_af[2] = cco_forwarded_almost_full;

      for (int c = 0; c < 3; c++) begin
        chk($sformatf("sb_cls%0d_valid", c), act_v[c], q[c].size() != 0);
        if (q[c].size() != 0) begin
          chk($sformatf("sb_cls%0d_payload", c), act_pl[c], q[c][0].pl);
          chk($sformatf("sb_cls%0d_dest", c), act_d[c], q[c][0].dest);
          if (c < 2) chk($sformatf("sb_cls%0d_has_data", c), act_hd[c], q[c][0].hd);
        end
        chk($sformatf("sb_cls%0d_almost_full", c), act_af[c], cnt[c] >= AF_AT);
      end
      chk("sb_overflow", cco_overflow_error, m_ovf);

      if (reset) begin
        for (int c = 0; c < 3; c++) begin q[c].delete(); cnt[c] = 0; end
        m_ovf = 1'b0;
      end else begin
        for (int c = 0; c < 3; c++) begin
          bit popping;
          popping = 1'b0;
          if (q[c].size() != 0 && av[c]) begin
            popping = q[c][0].last;
            void'(q[c].pop_front());
          end
          if (in_v[c] && in_dv[c] != 2'b00) begin
            if (cnt[c] < DEPTH || popping) begin
              cnt[c]++;
              case (in_dv[c])
                2'b10: q[c].push_back('{in_pl[c], in_hd[c], in_cc[c], 1'b1});
                2'b01: q[c].push_back('{in_pl[c], in_hd[c], in_dc[c], 1'b1});
                default: begin
                  q[c].push_back('{in_pl[c], in_hd[c], in_cc[c], 1'b0});
                  q[c].push_back('{in_pl[c], in_hd[c], in_dc[c], 1'b1});
                end
              endcase
            end else begin
              m_ovf = 1'b1;
            end
          end
          if (popping) cnt[c]--;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [1:0]       dv;
    tile_address_t    cc;
    tile_address_t    dc;
    logic [MSG_W-1:0] pl;
    logic             hd;
    int               nbeats;
    tile_address_t    d0;
    tile_address_t    d1;
  } vec_t;

  vec_t vt [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cc4_request_valid = 1'b0; cc4_request = '0; cc4_request_has_data = 1'b0;
    cc4_request_destinations = '0; cc4_request_destinations_valid = 2'b00;
    cc4_response_valid = 1'b0; cc4_response = '0; cc4_response_has_data = 1'b0;
    cc4_response_destinations = '0; cc4_response_destinations_valid = 2'b00;
    cc4_forwarded_request_valid = 1'b0; cc4_forwarded_request = '0;
    cc4_forwarded_request_destination = '0;
  endtask

  task automatic drive_req(input logic [1:0] dv, input tile_address_t cc, input tile_address_t dc,
                           input logic [MSG_W-1:0] pl, input logic hd);
    cc4_request_valid = 1'b1; cc4_request = coherence_request_message_t'(pl);
    cc4_request_has_data = hd; cc4_request_destinations_valid = dv;
    cc4_request_destinations[CC_ID] = cc; cc4_request_destinations[DC_ID] = dc;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  initial begin
    int n;
    logic [MSG_W-1:0] hold_pl;
    reset = 1'b1; ni_req = 1'b0; ni_rsp = 1'b0; ni_fwd = 1'b0;
    idle_inputs();
    @(posedge clk); started = 1'b1; #1;
    @(negedge clk);
    chk("reset_req_valid", cco_request_valid, 1'b0);
    chk("reset_overflow", cco_overflow_error, 1'b0);
    step(); reset = 1'b0;

    // Vector table: single request, NI always available
    vt[0] = '{2'b10, 4'h3, 4'h7, 40'h10_0000_0001, 1'b1, 1, 4'h3, 4'h0};
    vt[1] = '{2'b01, 4'h3, 4'h7, 40'h21_2345_6789, 1'b0, 1, 4'h7, 4'h0};
    vt[2] = '{2'b11, 4'h2, 4'h5, 40'h3A_BCDE_F012, 1'b1, 2, 4'h2, 4'h5};
    vt[3] = '{2'b00, 4'h1, 4'h1, 40'h4F_FFFF_FFFF, 1'b1, 0, 4'h0, 4'h0};
    vt[4] = '{2'b11, 4'hF, 4'h0, 40'h55_5555_5555, 1'b0, 2, 4'hF, 4'h0};
    vt[5] = '{2'b10, 4'h0, 4'h9, 40'h6C_0FFE_E000, 1'b1, 1, 4'h0, 4'h0};
    ni_req = 1'b1;
    for (int v = 0; v < 6; v++) begin
      drive_req(vt[v].dv, vt[v].cc, vt[v].dc, vt[v].pl, vt[v].hd);
      @(negedge clk);
      chk($sformatf("vec%0d_pre_valid", v), cco_request_valid, 1'b0);
      step(); idle_inputs();
      for (int b = 0; b < vt[v].nbeats; b++) begin
        @(negedge clk);
        chk($sformatf("vec%0d_beat%0d_valid", v, b), cco_request_valid, 1'b1);
        chk($sformatf("vec%0d_beat%0d_dest", v, b), cco_request_destination,
            (b == 0) ? vt[v].d0 : vt[v].d1);
        chk($sformatf("vec%0d_beat%0d_payload", v, b), cco_request, vt[v].pl);
        step();
      end
      @(negedge clk);
      chk($sformatf("vec%0d_empty", v), cco_request_valid, 1'b0);
      step();
    end
    ni_req = 1'b0;

    // Dual-destination response with NI stalled during the second beat
    ni_rsp = 1'b1; hold_pl = 40'h7B_DEAD_BEEF;
    cc4_response_valid = 1'b1; cc4_response = coherence_response_message_t'(hold_pl);
    cc4_response_has_data = 1'b1; cc4_response_destinations_valid = 2'b11;
    cc4_response_destinations[CC_ID] = 4'h2; cc4_response_destinations[DC_ID] = 4'h5;
    step(); idle_inputs();
    @(negedge clk);
    chk("rsp_first_dest", cco_response_destination, 4'h2);
    step(); ni_rsp = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rsp_stall_valid", cco_response_valid, 1'b1);
      chk("rsp_stall_dest", cco_response_destination, 4'h5);
      chk("rsp_stall_payload", cco_response, hold_pl);
      step();
    end
    ni_rsp = 1'b1;
    @(negedge clk);
    chk("rsp_second_dest", cco_response_destination, 4'h5);
    step();
    @(negedge clk);
    chk("rsp_popped", cco_response_valid, 1'b0);
    step();

    // Forwarded FIFO fill: almost-full threshold and overflow on the 9th push
    ni_fwd = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cc4_forwarded_request_valid = 1'b1;
      cc4_forwarded_request = coherence_forwarded_message_t'(40'h80_0000_0000 + MSG_W'(i));
      cc4_forwarded_request_destination = tile_address_t'(i);
      @(negedge clk);
      chk($sformatf("fwd_af_before_push%0d", i), cco_forwarded_almost_full, i >= AF_AT);
      chk($sformatf("fwd_ovf_before_push%0d", i), cco_overflow_error, 1'b0);
      step();
    end
    idle_inputs();
    @(negedge clk);
    chk("fwd_af_full", cco_forwarded_almost_full, 1'b1);
    chk("fwd_overflow_set", cco_overflow_error, 1'b1);
    step();
    ni_fwd = 1'b1; n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cco_forwarded_request_valid) n++;
      step();
    end
    chk("fwd_drain_beats", n, 8);
    ni_fwd = 1'b0;
    pulse_reset();

    // Full request FIFO with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 8; i++) begin
      drive_req(2'b10, tile_address_t'(i), 4'h0, 40'h90_0000_0000 + MSG_W'(i), 1'b0);
      step();
    end
    ni_req = 1'b1;
    for (int i = 8; i < 14; i++) begin
      drive_req(2'b10, tile_address_t'(i), 4'h0, 40'h90_0000_0000 + MSG_W'(i), 1'b0);
      @(negedge clk);
      chk("full_pushpop_af", cco_request_almost_full, 1'b1);
      chk("full_pushpop_ovf", cco_overflow_error, 1'b0);
      chk("full_pushpop_dest", cco_request_destination, tile_address_t'(i - 8));
      step();
    end
    idle_inputs(); n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cco_request_valid) n++;
      step();
    end
    chk("full_pushpop_remaining", n, 8);
    chk("full_pushpop_no_ovf", cco_overflow_error, 1'b0);
    ni_req = 1'b0;

    // Reset while the request serializer is on its second beat
    for (int i = 0; i < 3; i++) begin
      drive_req(2'b11, tile_address_t'(i + 1), tile_address_t'(i + 8), 40'hA0_0000_0000 + MSG_W'(i), 1'b1);
      if (i == 0) begin
        cc4_response_valid = 1'b1; cc4_response_destinations_valid = 2'b10;
        cc4_response_destinations[CC_ID] = 4'h6;
        cc4_forwarded_request_valid = 1'b1; cc4_forwarded_request_destination = 4'hC;
      end
      step(); idle_inputs();
    end
    ni_req = 1'b1;
    @(negedge clk);
    chk("rst_seq_first_dest", cco_request_destination, 4'h1);
    step(); ni_req = 1'b0;
    @(negedge clk);
    chk("rst_seq_second_dest", cco_request_destination, 4'h8);
    step();
    pulse_reset();
    @(negedge clk);
    chk("rst_seq_req_valid", cco_request_valid, 1'b0);
    chk("rst_seq_rsp_valid", cco_response_valid, 1'b0);
    chk("rst_seq_fwd_valid", cco_forwarded_request_valid, 1'b0);
    step();
    drive_req(2'b11, 4'h4, 4'h6, 40'hB0_1234_5678, 1'b0); ni_req = 1'b1;
    step(); idle_inputs();
    @(negedge clk);
    chk("rst_seq_restart_first", cco_request_destination, 4'h4);
    step();
    @(negedge clk);
    chk("rst_seq_restart_second", cco_request_destination, 4'h6);
    step();
    @(negedge clk);
    chk("rst_seq_restart_empty", cco_request_valid, 1'b0);
    step();

    // Random mixed traffic, checked by the scoreboard
    for (int k = 0; k < 400; k++) begin
      idle_inputs();
      ni_req = 1'($urandom_range(0, 1)); ni_rsp = 1'($urandom_range(0, 1));
      ni_fwd = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0)
        drive_req(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), MSG_W'({$urandom, $urandom}), 1'($urandom));
      if ($urandom_range(0, 2) != 0) begin
        cc4_response_valid = 1'b1;
        cc4_response = coherence_response_message_t'(MSG_W'({$urandom, $urandom}));
        cc4_response_has_data = 1'($urandom);
        cc4_response_destinations_valid = 2'($urandom_range(0, 3));
        cc4_response_destinations = 8'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        cc4_forwarded_request_valid = 1'b1;
        cc4_forwarded_request = coherence_forwarded_message_t'(MSG_W'({$urandom, $urandom}));
        cc4_forwarded_request_destination = 4'($urandom);
      end
      if (k == 200) reset = 1'b1;
      step();
      reset = 1'b0;
    end
    idle_inputs(); ni_req = 1'b1; ni_rsp = 1'b1; ni_fwd = 1'b1;
    repeat (40) step();
    @(negedge clk);
    chk("final_req_empty", cco_request_valid, 1'b0);
    chk("final_rsp_empty", cco_response_valid, 1'b0);
    chk("final_fwd_empty", cco_forwarded_request_valid, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
